// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for an eight-digit, common-anode seven-segment
//   display. A 32-bit value is latched into a shadow register on load_i.
//   One digit is scanned at a time, each digit lit for CLK_DIV cycles.
//   All pins are registered and active-low.
//
// Optional feature:
//   SEG7_LEADING_ZERO_BLANK_EN -- when defined, leading-zero digits 7..1 are
//   blanked. Digit 0 is always shown, so a value of 0 displays a single "0".
//
// Parameters:
//   CLK_DIV     cycles each digit stays lit (>= 1)
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   data_i      value to display; digit k shows data_i[4k+3:4k]
//   load_i      level-sensitive capture of data_i into the shadow register
//   digit_en_i  per-digit enable, sampled live (0 keeps that anode off)
//   dp_i        per-digit decimal-point request, sampled live, active-high
//   AN          anodes, active-low, at most one low at a time
//   SEG         cathodes {CA,CB,CC,CD,CE,CF,CG}, active-low
//   DP          decimal-point cathode, active-low
module seg7_scan_driver #(
    parameter int CLK_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_i,
    input  logic        load_i,
    input  logic [7:0]  digit_en_i,
    input  logic [7:0]  dp_i,
    output logic [7:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [31:0]      shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [2:0]       idx_q,    idx_d;
    logic [7:0]       an_q,     an_d;
    logic [6:0]       seg_q,    seg_d;
    logic             dp_q,     dp_d;

    logic [3:0]       nib;
    logic [6:0]       nib_seg;
    logic             blank;
    logic             lit;

    // Shadow capture and scan timebase.
    always_comb begin
        shadow_d = load_i ? data_i : shadow_q;
        cnt_d    = cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;   // natural 3-bit wrap 7 -> 0
        end
    end

    // Nibble select and hex decode from the current shadow/idx, so the
    // output register always pairs the anode with its own segment pattern.
    always_comb begin
        nib = shadow_q[{idx_q, 2'b00} +: 4];
        unique case (nib)
            4'h0: nib_seg = 7'b0000001;
            4'h1: nib_seg = 7'b1001111;
            4'h2: nib_seg = 7'b0010010;
            4'h3: nib_seg = 7'b0000110;
            4'h4: nib_seg = 7'b1001100;
            4'h5: nib_seg = 7'b0100100;
            4'h6: nib_seg = 7'b0100000;
            4'h7: nib_seg = 7'b0001111;
            4'h8: nib_seg = 7'b0000000;
            4'h9: nib_seg = 7'b0000100;
            4'hA: nib_seg = 7'b0001000;
            4'hB: nib_seg = 7'b1100000;
            4'hC: nib_seg = 7'b0110001;
            4'hD: nib_seg = 7'b1000010;
            4'hE: nib_seg = 7'b0110000;
            default: nib_seg = 7'b0111000;
        endcase
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Digit k is a leading zero when every nibble from k upward is zero.
    // Digit 0 is exempt so the value 0 still shows one "0".
    always_comb begin
        blank = (idx_q != 3'd0) && ((shadow_q >> {idx_q, 2'b00}) == 32'd0);
    end
`else
    always_comb begin
        blank = 1'b0;
    end
`endif

    always_comb begin
        lit   = digit_en_i[idx_q] && !blank;
        an_d  = 8'hFF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (lit) begin
            an_d  = ~(8'b1 << idx_q);
            seg_d = nib_seg;
            dp_d  = ~dp_i[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            an_q     <= 8'hFF;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
        end else begin
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign AN  = an_q;
    assign SEG = seg_q;
    assign DP  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (CLK_DIV=4).
// Reference model: the lit digit is (non-reset edges since reset / CLK_DIV) mod 8,
// taken from a plain shadow value and a hex lookup table.
module tb_seg7_scan_driver;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_i = '0;
    logic        load_i = 1'b0;
    logic [7:0]  digit_en_i = 8'hFF;
    logic [7:0]  dp_i = 8'h00;
    logic [7:0]  AN;
    logic [6:0]  SEG;
    logic        DP;

    int checks = 0;
    int errors = 0;

    // model state
    logic [31:0] m_shadow = '0;
    int          m_tick   = 0;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    int          lit_cnt;

    logic [6:0] hex_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    seg7_scan_driver #(.CLK_DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data_i),
        .load_i     (load_i),
        .digit_en_i (digit_en_i),
        .dp_i       (dp_i),
        .AN         (AN),
        .SEG        (SEG),
        .DP         (DP)
    );

    always #5 clk = ~clk;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock step: drive inputs, predict outputs from model state before the
    // edge, compare after the edge, then advance the model.
    task automatic step(input logic r, input logic ld, input logic [31:0] d,
                        input logic [7:0] en, input logic [7:0] dpv);
        int          k;
        logic [3:0]  nib;
        logic        blank;
        @(negedge clk);
        rst = r; load_i = ld; data_i = d; digit_en_i = en; dp_i = dpv;
        k   = (m_tick / DIV) % 8;
        nib = 4'((m_shadow >> (4 * k)) & 32'hF);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        blank = (k > 0) && ((m_shadow >> (4 * k)) == 32'd0);
`else
        blank = 1'b0;
`endif
        if (r || !en[k] || blank) begin
            e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
            e_an = ~(8'd1 << k); e_seg = hex_tab[nib]; e_dp = ~dpv[k];
        end
        @(posedge clk);
        #1;
        chk8("AN", AN, e_an);
        chk8("SEG", {1'b0, SEG}, {1'b0, e_seg});
        chk8("DP", {7'd0, DP}, {7'd0, e_dp});
        if (!r && AN != 8'hFF) lit_cnt++;
        if (r) begin
            m_shadow = '0;
            m_tick   = 0;
        end else begin
            if (ld) m_shadow = d;
            m_tick++;
        end
    endtask

    initial begin
        // 1. reset held 3 cycles, then first digit
        repeat (3) step(1, 0, 32'h0, 8'hFF, 8'h00);
        step(0, 0, 32'h0, 8'hFF, 8'h00);
        chk8("first_after_reset_AN", AN, 8'hFE);

        // 2. cadence with 01234567 (load during digit 0 slot)
        step(0, 1, 32'h01234567, 8'hFF, 8'h00);
        repeat (6) step(0, 0, 32'h0, 8'hFF, 8'h00);   // m_tick now 8: digit 2 next
        // 3. load FFFFFFFF while digit 2 is lit; next edge shows F
        step(0, 1, 32'hFFFFFFFF, 8'hFF, 8'h00);
        step(0, 0, 32'h0, 8'hFF, 8'h00);
        chk8("load_next_SEG", {1'b0, SEG}, 8'b0111000);
        repeat (3) step(0, 0, 32'h0, 8'hFF, 8'h00);
        chk8("load_persist_SEG", {1'b0, SEG}, 8'b0111000);
        step(0, 1, 32'h01234567, 8'hFF, 8'h00);
        repeat (40) step(0, 0, 32'h0, 8'hFF, 8'h00);

        // 4. enables and decimal point
        repeat (40) step(0, 0, 32'h0, 8'h0F, 8'h02);

        // 5. leading zeros: count lit cycles over one frame
        step(0, 1, 32'h000000A5, 8'hFF, 8'h00);
        repeat (8 * DIV) step(0, 0, 32'h0, 8'hFF, 8'h00);
        lit_cnt = 0;
        repeat (8 * DIV) step(0, 0, 32'h0, 8'hFF, 8'h00);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        chk8("blank_lit_cycles", 8'(lit_cnt), 8'(2 * DIV));
`else
        chk8("noblank_lit_cycles", 8'(lit_cnt), 8'(8 * DIV));
`endif

        // 6. reset mid-scan at idx=5, cnt=2 with load_i high
        step(1, 0, 32'h0, 8'hFF, 8'h00);
        step(0, 1, 32'h89ABCDEF, 8'hFF, 8'h00);
        repeat (5 * DIV + 1) step(0, 0, 32'h0, 8'hFF, 8'hFF);
        step(1, 1, 32'h12345678, 8'hFF, 8'hFF);
        chk8("midscan_reset_AN", AN, 8'hFF);
        step(0, 0, 32'h0, 8'hFF, 8'hFF);
        chk8("restart_AN", AN, 8'hFE);
        chk8("restart_SEG_zero", {1'b0, SEG}, 8'b0000001);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 7) == 0),
                 $urandom(),
                 ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'hFF,
                 8'($urandom()));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
